// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock monitor.
// Optional min/max period stats: CLK_MON_STATS_EN.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } clk_mon_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] max
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/clk_mon_sync.sv
// Synchronizer plus registered edge detect; level, rise
// and fall are aligned, three clk edges after the input.
module clk_mon_sync
  import clk_mon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], sig};
      level <= sync[SYNC_STAGES-1];
      rise  <= sync[SYNC_STAGES-1] & ~level;
      fall  <= ~sync[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/clk_monitor.sv
// Measures period/high time of mon_clk in clk cycles.
// Define CLK_MON_STATS_EN for min_period/max_period.
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int EXP_HIGH   = 5,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_clk,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             freq_err,
  output logic             duty_err,
`ifdef CLK_MON_STATS_EN
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
`endif
  output logic             lost,
  output logic             locked
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [31:0] P_LO =
    (EXP_PERIOD > TOL) ? 32'(EXP_PERIOD - TOL) : 32'd0;
  localparam logic [31:0] P_HI = 32'(EXP_PERIOD + TOL);
  localparam logic [31:0] H_LO =
    (EXP_HIGH > TOL) ? 32'(EXP_HIGH - TOL) : 32'd0;
  localparam logic [31:0] H_HI = 32'(EXP_HIGH + TOL);

  logic level, rise, fall;

  clk_mon_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .sig   (mon_clk),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  clk_mon_state_t state;
  logic [CNT_W-1:0] hi_cnt, lo_cnt, idle_ctr;
  logic [CNT_W-1:0] period, hi_inc, lo_inc;
  logic [LW-1:0] lock_nxt, lock_ctr;
  logic p_err, h_err, timeout;

  always_comb begin
    period = CNT_W'(sat_add(32'(hi_cnt), 32'(lo_cnt),
                            32'(CNT_MAX)));
    hi_inc = CNT_W'(sat_add(32'(hi_cnt), 32'd1, 32'(CNT_MAX)));
    lo_inc = CNT_W'(sat_add(32'(lo_cnt), 32'd1, 32'(CNT_MAX)));
    p_err = (32'(period) < P_LO) || (32'(period) > P_HI);
    h_err = (32'(hi_cnt) < H_LO) || (32'(hi_cnt) > H_HI);
    lock_nxt = (lock_ctr == LOCK_MAX) ? LOCK_MAX
                                      : lock_ctr + LW'(1);
    timeout = (state != IDLE) && !rise && !fall &&
              (idle_ctr == TO - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      idle_ctr    <= '0;
      lock_ctr    <= '0;
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      freq_err    <= 1'b0;
      duty_err    <= 1'b0;
      lost        <= 1'b0;
      locked      <= 1'b0;
`ifdef CLK_MON_STATS_EN
      min_period  <= '1;
      max_period  <= '0;
`endif
    end else if (!enable) begin
      state      <= IDLE;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      idle_ctr   <= '0;
      lock_ctr   <= '0;
      meas_valid <= 1'b0;
      lost       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // Edge-free watchdog; saturates so it fires once.
      if (state != IDLE) begin
        if (rise || fall)
          idle_ctr <= '0;
        else if (idle_ctr != TO)
          idle_ctr <= idle_ctr + CNT_W'(1);
        if (timeout) begin
          lost     <= 1'b1;
          locked   <= 1'b0;
          lock_ctr <= '0;
        end
      end
      unique case (state)
        IDLE: begin
          state    <= ARM;
          idle_ctr <= '0;
`ifdef CLK_MON_STATS_EN
          min_period <= '1;
          max_period <= '0;
`endif
        end
        ARM: begin
          if (rise) begin
            state  <= MEASURE;
            hi_cnt <= CNT_W'(1);
            lo_cnt <= CNT_W'(1);
            lost   <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            meas_valid  <= 1'b1;
            meas_period <= period;
            meas_high   <= hi_cnt;
            freq_err    <= p_err;
            duty_err    <= h_err;
            lost        <= 1'b0;
            hi_cnt      <= CNT_W'(1);
            lo_cnt      <= '0;
            if (p_err || h_err) begin
              lock_ctr <= '0;
              locked   <= 1'b0;
            end else begin
              lock_ctr <= lock_nxt;
              locked   <= (lock_nxt == LOCK_MAX);
            end
`ifdef CLK_MON_STATS_EN
            if (period < min_period) min_period <= period;
            if (period > max_period) max_period <= period;
`endif
          end else begin
            if (level) hi_cnt <= hi_inc;
            else       lo_cnt <= lo_inc;
            if (timeout) state <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: lock, freq/duty errors,
// loss of clock, enable drop and reset.
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mon_clk;
  logic        meas_valid;
  logic [15:0] meas_period;
  logic [15:0] meas_high;
  logic        freq_err;
  logic        duty_err;
  logic        lost;
  logic        locked;
`ifdef CLK_MON_STATS_EN
  logic [15:0] min_period;
  logic [15:0] max_period;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int mp[$];
  int mh[$];
  int fe[$];
  int de[$];
  int lk[$];

  always #5 clk = ~clk;

  clk_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mon_clk     (mon_clk),
    .meas_valid  (meas_valid),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .freq_err    (freq_err),
    .duty_err    (duty_err),
`ifdef CLK_MON_STATS_EN
    .min_period  (min_period),
    .max_period  (max_period),
`endif
    .lost        (lost),
    .locked      (locked)
  );

  always @(negedge clk) begin
    if (meas_valid) begin
      mp.push_back(int'(meas_period));
      mh.push_back(int'(meas_high));
      fe.push_back(int'(freq_err));
      de.push_back(int'(duty_err));
      lk.push_back(int'(locked));
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_mon(input int period,
                           input int high,
                           input int n);
    for (int i = 0; i < n; i++) begin
      mon_clk = 1'b1;
      repeat (high) @(negedge clk);
      mon_clk = 1'b0;
      repeat (period - high) @(negedge clk);
    end
  endtask

  task automatic clear_q();
    mp.delete();
    mh.delete();
    fe.delete();
    de.delete();
    lk.delete();
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    mon_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_period", 32'(meas_period), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal clock: first period counts from the arming rise
    drive_mon(10, 5, 6);
    check("nom_count", 32'(mp.size()), 32'd5);
    check("nom_first_per", 32'(mp[0]), 32'd11);
    check("nom_per", 32'(mp[1]), 32'd10);
    check("nom_high", 32'(mh[1]), 32'd5);
    check("nom_ferr", 32'(fe[4]), 32'd0);
    check("nom_derr", 32'(de[4]), 32'd0);
    check("nom_lk3", 32'(lk[2]), 32'd0);
    check("nom_lk4", 32'(lk[3]), 32'd1);

    // Period 12 after lock
    clear_q();
    drive_mon(12, 6, 3);
    check("f12_prev_lk", 32'(lk[0]), 32'd1);
    check("f12_per", 32'(mp[1]), 32'd12);
    check("f12_ferr", 32'(fe[1]), 32'd1);
    check("f12_derr", 32'(de[1]), 32'd0);
    check("f12_lk", 32'(lk[1]), 32'd0);
    clear_q();
    drive_mon(10, 5, 5);
    check("relock_ferr", 32'(fe[1]), 32'd0);
    check("relock_lk3", 32'(lk[3]), 32'd0);
    check("relock_lk4", 32'(lk[4]), 32'd1);

    // Duty error
    clear_q();
    drive_mon(10, 7, 5);
    check("d7_high", 32'(mh[1]), 32'd7);
    check("d7_derr", 32'(de[1]), 32'd1);
    check("d7_ferr", 32'(fe[1]), 32'd0);
    check("d7_lk", 32'(lk[4]), 32'd0);

    // Loss of clock
    drive_mon(10, 5, 6);
    check("pre_lost_lk", 32'(locked), 32'd1);
    mon_clk = 1'b1;
    repeat (1000) @(negedge clk);
    check("lost_early", 32'(lost), 32'd0);
    repeat (40) @(negedge clk);
    check("lost_set", 32'(lost), 32'd1);
    check("lost_lk", 32'(locked), 32'd0);
    mon_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("lost_after_fall", 32'(lost), 32'd1);
    mon_clk = 1'b1;
    repeat (5) @(negedge clk);
    check("lost_cleared", 32'(lost), 32'd0);

    // Enable drop mid-period
    mon_clk = 1'b0;
    repeat (5) @(negedge clk);
    drive_mon(10, 5, 5);
    check("en_pre_lk", 32'(locked), 32'd1);
    mon_clk = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("en_off_lk", 32'(locked), 32'd0);
    check("en_off_hold", 32'(meas_period), 32'd10);
    enable = 1'b1;
    mon_clk = 1'b0;
    repeat (5) @(negedge clk);
    clear_q();
    drive_mon(10, 5, 1);
    check("en_arm_only", 32'(mp.size()), 32'd0);
    drive_mon(10, 5, 1);
    check("en_one_meas", 32'(mp.size()), 32'd1);
    check("en_first_per", 32'(mp[0]), 32'd11);

    // Reset mid-period
    clear_q();
    mon_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(meas_valid), 32'd0);
    check("mrst_period", 32'(meas_period), 32'd0);
    check("mrst_high", 32'(meas_high), 32'd0);
    check("mrst_ferr", 32'(freq_err), 32'd0);
    check("mrst_lk", 32'(locked), 32'd0);
`ifdef CLK_MON_STATS_EN
    check("mrst_min", 32'(min_period), 32'hFFFF);
    check("mrst_max", 32'(max_period), 32'd0);
`endif
    rst = 1'b0;
    mon_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("mrst_no_meas", 32'(mp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
Synthesizable checker that measures an incoming clock (`mon_clk`) against the system clock `clk`. It reports the period and high time of each cycle of `mon_clk` as counts of `clk` cycles, and flags frequency and duty-cycle errors and loss of clock. It also asserts lock after a run of in-tolerance periods. It is the receiving end of our clock generators: it sits on the consumer side of every generated clock, and it is used in silicon as well as in benches.

Parameters:
CNT_W, 16, width of all measurement counters and outputs
EXP_PERIOD, 10, expected `mon_clk` period in `clk` cycles
EXP_HIGH, 5, expected high time in `clk` cycles
TOL, 1, allowed +/- deviation in `clk` cycles for period and high time
LOCK_CNT, 4, consecutive good periods required to assert `locked`
TIMEOUT, 1023, `clk` cycles without a detected `mon_clk` edge before `lost` asserts

Ports:
clk  input  1  system sampling clock
rst  input  1  synchronous, active-high reset
enable  input  1  monitor enable; low forces IDLE
mon_clk  input  1  monitored clock, asynchronous to `clk`
meas_valid  output  1  one-cycle pulse; `meas_*` outputs updated this cycle
meas_period  output  CNT_W  last measured period (`clk` cycles)
meas_high  output  CNT_W  last measured high time (`clk` cycles)
freq_err  output  1  last period outside EXP_PERIOD +/- TOL (sticky until next `meas_valid`)
duty_err  output  1  last high time outside EXP_HIGH +/- TOL (sticky until next `meas_valid`)
lost  output  1  no `mon_clk` edge for TIMEOUT cycles
locked  output  1  LOCK_CNT consecutive error-free periods seen

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`. On reset every output is 0, the FSM goes to IDLE, and all counters clear.
- Input sampling: `mon_clk` passes through a 2-flop synchronizer, then an edge-detect flop. `rise`/`fall` pulses appear 3 `clk` edges after the raw transition.
- States:
  - IDLE -> ARM when `enable`=1.
  - ARM -> MEASURE on the first `rise`; `hi_cnt` and `lo_cnt` load 1.
  - MEASURE -> ARM on timeout.
  - Any state -> IDLE when `enable`=0. This clears `locked`, `lost` and `lock_ctr`; `meas_*` hold their values.
- Counting in MEASURE:
  - While the synchronized level is 1, `hi_cnt` increments; while it is 0, `lo_cnt` increments.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - `rise` in MEASURE completes a period: `meas_period` <= `hi_cnt`+`lo_cnt`, saturating, computed at CNT_W+1 bits and clamped. `meas_high` <= `hi_cnt`.
  - In the same cycle as that `rise`: `meas_valid`=1, `freq_err`/`duty_err` update, `hi_cnt` reloads 1, `lo_cnt` clears.
  - Latency: the outputs reflect a period one `clk` cycle after the detected `rise`, and are registered.
- Error checks: compare with `>=` and `<=` against EXP-TOL and EXP+TOL. EXP-TOL clamps at 0.
- Lock:
  - An error-free `meas_valid` increments `lock_ctr`, saturating at LOCK_CNT. `locked`=1 when `lock_ctr`==LOCK_CNT.
  - Any error clears `lock_ctr` and `locked` in the same update.
- Timeout:
  - `idle_ctr` counts cycles with no `rise` or `fall` in ARM or MEASURE.
  - When it reaches TIMEOUT: `lost`=1, `locked`=0, `lock_ctr`=0, and MEASURE -> ARM.
  - `lost` clears on the next `rise`.
- Simultaneous events: timeout and `rise` in the same cycle is treated as `rise`, so no `lost`. `enable` falling has priority over everything except `rst`.
- `rst` mid-measurement discards the partial period; no `meas_valid` is produced for it.

Optional Feature:
- Macro: `CLK_MON_STATS_EN`.
- With it defined: extra outputs `min_period` and `max_period` (CNT_W each) update on every `meas_valid`.
  - Reset values: `min_period`=all ones, `max_period`=0.
  - Both re-initialize when leaving IDLE.
- Without it: those ports and registers are absent, and the rest of the behaviour is identical.

Decomposition:
- Package `clk_mon_pkg`:
  - state enum `clk_mon_state_t` {IDLE, ARM, MEASURE}
  - sync depth constant SYNC_STAGES=2
  - a saturating-add function
- Sub-module `clk_mon_sync`: 2-flop synchronizer plus edge detect, producing `level`, `rise` and `fall`. It is shared with future phase-compare blocks.

Test Plan:
- `mon_clk` with period 10 `clk`, high 5 -> `meas_valid` every 10 cycles with `meas_period`=10 and `meas_high`=5; `locked`=1 after the 4th measurement; no errors.
- `mon_clk` with period 10, high 7 -> `duty_err`=1, `freq_err`=0, `locked` stays 0.
- Lock first, then change the period to 12 -> `freq_err`=1 and `locked` drops on that `meas_valid`; `lock_ctr` restarts from 0.
- Stop `mon_clk` high after lock -> `lost`=1 after 1023 cycles with no edge and `locked`=0; restarting `mon_clk` clears `lost` on the first `rise`.
- Deassert `enable` mid-period, then reassert -> FSM passes through IDLE and ARM, and the first `meas_valid` comes only after two full rises.
- Assert `rst` mid-period -> all outputs 0 the next cycle; with `CLK_MON_STATS_EN`, `min_period`=0xFFFF.
